// File: rtl/cmd_exec_pkg.sv
// cmd_exec_pkg: opcodes, FSM states, command field positions
// and default tuning constants for the move-command responder.
package cmd_exec_pkg;

  typedef enum logic [3:0] {
    OP_CAL      = 4'h0,
    OP_MOVE     = 4'h2,
    OP_MOVE_FAN = 4'h3
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    CAL,
    TURN,
    RAMP,
    DECEL
  } state_t;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int HDG_MSB = 11;
  localparam int HDG_LSB = 4;
  localparam int SQ_MSB  = 3;
  localparam int SQ_LSB  = 0;

  localparam logic [10:0] MAX_SPD_DEF    = 11'h2A0;
  localparam logic [10:0] SPD_INC_DEF    = 11'd4;
  localparam logic [10:0] SPD_DEC_DEF    = 11'd8;
  localparam logic [11:0] ERR_THRESH_DEF = 12'd30;

endpackage

// File: rtl/cmd_exec_if.sv
// cmd_exec_if: 16-bit command handshake between the cmd mux
// (master) and the command responder (slave).
interface cmd_exec_if;

  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;

  modport master (
    output cmd,
    output cmd_rdy,
    input  clr_cmd_rdy,
    input  send_resp
  );

  modport slave (
    input  cmd,
    input  cmd_rdy,
    output clr_cmd_rdy,
    output send_resp
  );

endinterface

// File: rtl/cmd_exec_sq_counter.sv
// cmd_exec_sq_counter: cntrIR synchronizer, rising-edge detect and
// saturating square count. CMD_EXEC_FAST_SIM_EN selects a 1-flop sync.
module cmd_exec_sq_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cntrIR,
  input  logic       en,
  input  logic       clr,
  input  logic [3:0] squares,
  output logic       done
);

  logic       rise;
  logic [3:0] count;

`ifdef CMD_EXEC_FAST_SIM_EN
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= cntrIR;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;
`else
  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], cntrIR};
      prev_q <= sync_q[1];
    end
  end

  assign rise = sync_q[1] & ~prev_q;
`endif

  assign done = (count == squares);

  // Count stops once it matches squares, so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (clr) begin
      count <= 4'd0;
    end else if (en && rise && !done) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/cmd_exec.sv
// cmd_exec: accepts calibrate/move commands, turns, ramps, counts
// squares, decelerates and responds. Macro: CMD_EXEC_FAST_SIM_EN.
module cmd_exec
  import cmd_exec_pkg::*;
#(
  parameter logic [10:0] MAX_SPD    = MAX_SPD_DEF,
  parameter logic [10:0] SPD_INC    = SPD_INC_DEF,
  parameter logic [10:0] SPD_DEC    = SPD_DEC_DEF,
  parameter logic [11:0] ERR_THRESH = ERR_THRESH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  cmd_exec_if.slave   bus,
  output logic        strt_cal,
  input  logic        cal_done,
  input  logic [11:0] error,
  input  logic        cntrIR,
  output logic [11:0] desired_heading,
  output logic        moving,
  output logic [10:0] frwrd_spd,
  output logic        fanfare_go
);

`ifdef CMD_EXEC_FAST_SIM_EN
  localparam logic [10:0] INC = SPD_INC << 2;
  localparam logic [10:0] DEC = SPD_DEC << 2;
`else
  localparam logic [10:0] INC = SPD_INC;
  localparam logic [10:0] DEC = SPD_DEC;
`endif

  state_t      state;
  state_t      state_n;
  logic [3:0]  op_q;
  logic [3:0]  op_n;
  logic [3:0]  sq_q;
  logic [3:0]  sq_n;
  logic        resp_q;
  logic        resp_n;
  logic        cal_n;
  logic        fan_n;
  logic [11:0] hdg_n;
  logic [10:0] spd_n;
  logic        accept;
  logic        sq_clr;
  logic        sq_done;
  logic        ramp_en;

  logic [3:0]  cmd_op;
  logic [7:0]  cmd_hdg;
  logic [3:0]  cmd_sq;

  assign cmd_op  = bus.cmd[OP_MSB:OP_LSB];
  assign cmd_hdg = bus.cmd[HDG_MSB:HDG_LSB];
  assign cmd_sq  = bus.cmd[SQ_MSB:SQ_LSB];

  logic signed [12:0] err_x;
  logic signed [12:0] thr_x;
  logic               err_ok;

  assign err_x  = {error[11], error};
  assign thr_x  = {1'b0, ERR_THRESH};
  assign err_ok = (err_x < thr_x) && (err_x > -thr_x);

  logic [11:0] up_sum;
  logic [10:0] spd_up;
  logic [10:0] spd_dn;

  assign up_sum = {1'b0, frwrd_spd} + {1'b0, INC};
  assign spd_up = (up_sum >= {1'b0, MAX_SPD}) ? MAX_SPD : up_sum[10:0];
  assign spd_dn = (frwrd_spd <= DEC) ? 11'd0 : frwrd_spd - DEC;

  assign ramp_en = (state == RAMP);

  cmd_exec_sq_counter u_sq (
    .clk     (clk),
    .rst_n   (rst_n),
    .cntrIR  (cntrIR),
    .en      (ramp_en),
    .clr     (sq_clr),
    .squares (sq_q),
    .done    (sq_done)
  );

  always_comb begin
    state_n = state;
    op_n    = op_q;
    sq_n    = sq_q;
    resp_n  = 1'b0;
    cal_n   = 1'b0;
    fan_n   = 1'b0;
    hdg_n   = desired_heading;
    spd_n   = frwrd_spd;
    accept  = 1'b0;
    sq_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cmd_rdy) begin
          accept = 1'b1;
          op_n   = cmd_op;
          sq_n   = cmd_sq;
          unique case (1'b1)
            (cmd_op == OP_CAL): begin
              cal_n   = 1'b1;
              state_n = CAL;
            end
            (cmd_op == OP_MOVE),
            (cmd_op == OP_MOVE_FAN): begin
              hdg_n   = (cmd_hdg == 8'd0) ? 12'h000
                                          : {cmd_hdg, 4'hF};
              sq_clr  = 1'b1;
              spd_n   = 11'd0;
              state_n = TURN;
            end
            default: resp_n = 1'b1;
          endcase
        end
      end
      CAL: begin
        if (cal_done) begin
          resp_n  = 1'b1;
          state_n = IDLE;
        end
      end
      TURN: begin
        spd_n = 11'd0;
        if (err_ok) state_n = RAMP;
      end
      RAMP: begin
        spd_n = spd_up;
        if (sq_done) state_n = DECEL;
      end
      DECEL: begin
        if (frwrd_spd == 11'd0) begin
          resp_n  = 1'b1;
          fan_n   = (op_q == OP_MOVE_FAN);
          state_n = IDLE;
        end else begin
          spd_n = spd_dn;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      op_q            <= 4'd0;
      sq_q            <= 4'd0;
      resp_q          <= 1'b0;
      strt_cal        <= 1'b0;
      fanfare_go      <= 1'b0;
      desired_heading <= 12'h000;
      frwrd_spd       <= 11'd0;
    end else begin
      state           <= state_n;
      op_q            <= op_n;
      sq_q            <= sq_n;
      resp_q          <= resp_n;
      strt_cal        <= cal_n;
      fanfare_go      <= fan_n;
      desired_heading <= hdg_n;
      frwrd_spd       <= spd_n;
    end
  end

  // Gated so the ack stays low while reset is held.
  assign bus.clr_cmd_rdy = accept & rst_n;
  assign bus.send_resp   = resp_q;
  assign moving = (state == TURN) || (state == RAMP) || (state == DECEL);

endmodule

// File: tb/tb_cmd_exec.sv
// tb_cmd_exec: directed scenarios for cmd_exec with
// hand-computed cycle-exact expectations.
module tb_cmd_exec;

  logic        clk;
  logic        rst_n;
  logic        strt_cal;
  logic        cal_done;
  logic [11:0] error;
  logic        cntrIR;
  logic [11:0] desired_heading;
  logic        moving;
  logic [10:0] frwrd_spd;
  logic        fanfare_go;

  int checks   = 0;
  int failures = 0;

  cmd_exec_if bus ();

  cmd_exec dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .strt_cal        (strt_cal),
    .cal_done        (cal_done),
    .error           (error),
    .cntrIR          (cntrIR),
    .desired_heading (desired_heading),
    .moving          (moving),
    .frwrd_spd       (frwrd_spd),
    .fanfare_go      (fanfare_go)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.cmd     = 16'h0000;
    bus.cmd_rdy = 1'b0;
    cal_done    = 1'b0;
    error       = 12'd0;
    cntrIR      = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.clr_cmd_rdy, bus.send_resp, strt_cal,
         moving, fanfare_go} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000",
        {bus.clr_cmd_rdy, bus.send_resp, strt_cal, moving, fanfare_go});
    end
    checks++;
    if (frwrd_spd !== 11'd0 || desired_heading !== 12'h000) begin
      failures++;
      $display("FAIL reset_regs spd=%0h hdg=%0h exp=0/0",
        frwrd_spd, desired_heading);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_cal();
    @(negedge clk);
    bus.cmd = 16'h0000;
    bus.cmd_rdy = 1'b1;
    #1;
    checks++;
    if (bus.clr_cmd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL cal_ack got=%b exp=1", bus.clr_cmd_rdy);
    end
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    checks++;
    if (strt_cal !== 1'b1 || bus.clr_cmd_rdy !== 1'b0) begin
      failures++;
      $display("FAIL cal_start strt_cal=%b clr=%b exp=1/0",
        strt_cal, bus.clr_cmd_rdy);
    end
    @(negedge clk);
    checks++;
    if (strt_cal !== 1'b0 || bus.send_resp !== 1'b0) begin
      failures++;
      $display("FAIL cal_wait strt_cal=%b resp=%b exp=0/0",
        strt_cal, bus.send_resp);
    end
    cal_done = 1'b1;
    @(negedge clk);
    cal_done = 1'b0;
    checks++;
    if (bus.send_resp !== 1'b1 || fanfare_go !== 1'b0) begin
      failures++;
      $display("FAIL cal_resp resp=%b fan=%b exp=1/0",
        bus.send_resp, fanfare_go);
    end
    @(negedge clk);
    checks++;
    if (bus.send_resp !== 1'b0) begin
      failures++;
      $display("FAIL cal_resp_pulse got=%b exp=0", bus.send_resp);
    end
  endtask

  task automatic test_move();
    logic ok;
    @(negedge clk);
    bus.cmd = 16'h23F2;
    bus.cmd_rdy = 1'b1;
    error = 12'd100;
    #1;
    checks++;
    if (bus.clr_cmd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL move_ack got=%b exp=1", bus.clr_cmd_rdy);
    end
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    checks++;
    if (desired_heading !== 12'h3FF || moving !== 1'b1) begin
      failures++;
      $display("FAIL move_hdg hdg=%0h mov=%b exp=3ff/1",
        desired_heading, moving);
    end
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (frwrd_spd !== 11'd0 || moving !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL turn_hold spd=%0h mov=%b exp=0/1", frwrd_spd, moving);
    end
    error = 12'd30;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (frwrd_spd !== 11'd0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL turn_pos30 spd=%0h exp=0", frwrd_spd);
    end
    error = 12'hFE2;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (frwrd_spd !== 11'd0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL turn_neg30 spd=%0h exp=0", frwrd_spd);
    end
    error = 12'd5;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 2 && frwrd_spd !== 11'd4) begin
        failures++;
        $display("FAIL ramp_first got=%0d exp=4", frwrd_spd);
      end
      if (i == 3 && frwrd_spd !== 11'd8) begin
        failures++;
        $display("FAIL ramp_second got=%0d exp=8", frwrd_spd);
      end
      if (i == 10 && frwrd_spd !== 11'd36) begin
        failures++;
        $display("FAIL move_peak got=%0d exp=36", frwrd_spd);
      end
      if (i == 11 && frwrd_spd !== 11'd28) begin
        failures++;
        $display("FAIL decel_step got=%0d exp=28", frwrd_spd);
      end
      if (i == 15 && (frwrd_spd !== 11'd0 || bus.send_resp !== 1'b0
                      || moving !== 1'b1)) begin
        failures++;
        $display("FAIL decel_zero spd=%0d resp=%b mov=%b exp=0/0/1",
          frwrd_spd, bus.send_resp, moving);
      end
      if (i == 16 && (bus.send_resp !== 1'b1 || moving !== 1'b0
                      || fanfare_go !== 1'b0)) begin
        failures++;
        $display("FAIL move_resp resp=%b mov=%b fan=%b exp=1/0/0",
          bus.send_resp, moving, fanfare_go);
      end
      if (i == 17 && bus.send_resp !== 1'b0) begin
        failures++;
        $display("FAIL move_resp_pulse got=%b exp=0", bus.send_resp);
      end
      cntrIR = ((i >= 2 && i < 4) || (i >= 6 && i < 8));
    end
    checks += 7;
  endtask

  task automatic test_fanfare();
    logic found;
    @(negedge clk);
    bus.cmd = 16'h3002;
    bus.cmd_rdy = 1'b1;
    error = 12'd0;
    found = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.cmd_rdy = 1'b0;
        checks++;
        if (desired_heading !== 12'h000) begin
          failures++;
          $display("FAIL fan_hdg got=%0h exp=000", desired_heading);
        end
      end
      if (bus.send_resp === 1'b1) begin
        found = 1'b1;
        checks++;
        if (fanfare_go !== 1'b1) begin
          failures++;
          $display("FAIL fan_pulse got=%b exp=1", fanfare_go);
        end
        break;
      end
      cntrIR = ((i >= 3 && i < 5) || (i >= 7 && i < 9));
    end
    cntrIR = 1'b0;
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL fan_timeout resp=%b exp=1", bus.send_resp);
    end
    @(negedge clk);
    checks++;
    if (fanfare_go !== 1'b0 || bus.send_resp !== 1'b0) begin
      failures++;
      $display("FAIL fan_end fan=%b resp=%b exp=0/0",
        fanfare_go, bus.send_resp);
    end
  endtask

  task automatic test_saturate();
    logic found;
    @(negedge clk);
    bus.cmd = 16'h2501;
    bus.cmd_rdy = 1'b1;
    error = 12'd0;
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    checks++;
    if (desired_heading !== 12'h50F) begin
      failures++;
      $display("FAIL sat_hdg got=%0h exp=50f", desired_heading);
    end
    repeat (200) @(negedge clk);
    checks++;
    if (frwrd_spd !== 11'h2A0) begin
      failures++;
      $display("FAIL sat_max got=%0h exp=2a0", frwrd_spd);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (frwrd_spd !== 11'h2A0 || moving !== 1'b1) begin
      failures++;
      $display("FAIL sat_hold spd=%0h mov=%b exp=2a0/1", frwrd_spd, moving);
    end
    cntrIR = 1'b1;
    repeat (2) @(negedge clk);
    cntrIR = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.send_resp === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || fanfare_go !== 1'b0) begin
      failures++;
      $display("FAIL sat_resp found=%b fan=%b exp=1/0", found, fanfare_go);
    end
  endtask

  task automatic test_unknown();
    @(negedge clk);
    bus.cmd = 16'h1234;
    bus.cmd_rdy = 1'b1;
    #1;
    checks++;
    if (bus.clr_cmd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL unk_ack got=%b exp=1", bus.clr_cmd_rdy);
    end
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    checks++;
    if (bus.send_resp !== 1'b1 || moving !== 1'b0 || strt_cal !== 1'b0
        || desired_heading !== 12'h50F) begin
      failures++;
      $display("FAIL unk_resp resp=%b mov=%b cal=%b hdg=%0h exp=1/0/0/50f",
        bus.send_resp, moving, strt_cal, desired_heading);
    end
  endtask

  task automatic test_back_to_back();
    logic        no_ack;
    logic [10:0] peak;
    @(negedge clk);
    bus.cmd = 16'h2000;
    bus.cmd_rdy = 1'b1;
    error = 12'd0;
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    @(negedge clk);
    bus.cmd = 16'h0000;
    bus.cmd_rdy = 1'b1;
    no_ack = 1'b1;
    peak = 11'd0;
    for (int i = 2; i <= 4; i++) begin
      if (i > 2) @(negedge clk);
      #1;
      if (bus.clr_cmd_rdy !== 1'b0) no_ack = 1'b0;
      if (frwrd_spd > peak) peak = frwrd_spd;
    end
    checks++;
    if (!no_ack) begin
      failures++;
      $display("FAIL b2b_no_ack got=1 exp=0");
    end
    checks++;
    if (peak !== 11'd4) begin
      failures++;
      $display("FAIL b2b_peak got=%0d exp=4", peak);
    end
    @(negedge clk);
    checks++;
    if (bus.clr_cmd_rdy !== 1'b1 || bus.send_resp !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle clr=%b resp=%b exp=1/1",
        bus.clr_cmd_rdy, bus.send_resp);
    end
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    checks++;
    if (strt_cal !== 1'b1) begin
      failures++;
      $display("FAIL b2b_cal got=%b exp=1", strt_cal);
    end
    cal_done = 1'b1;
    @(negedge clk);
    cal_done = 1'b0;
    checks++;
    if (bus.send_resp !== 1'b1) begin
      failures++;
      $display("FAIL b2b_cal_resp got=%b exp=1", bus.send_resp);
    end
  endtask

  task automatic test_reset_mid();
    logic quiet;
    @(negedge clk);
    bus.cmd = 16'h2101;
    bus.cmd_rdy = 1'b1;
    error = 12'd0;
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (frwrd_spd !== 11'd32 || moving !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre spd=%0d mov=%b exp=32/1", frwrd_spd, moving);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.clr_cmd_rdy, bus.send_resp, strt_cal, moving, fanfare_go,
         frwrd_spd, desired_heading} !== 28'd0) begin
      failures++;
      $display("FAIL rst_async spd=%0h hdg=%0h mov=%b exp=0/0/0",
        frwrd_spd, desired_heading, moving);
    end
    quiet = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.send_resp !== 1'b0) quiet = 1'b0;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.send_resp !== 1'b0 || moving !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL rst_no_resp got=1 exp=0");
    end
    bus.cmd = 16'h0000;
    bus.cmd_rdy = 1'b1;
    #1;
    checks++;
    if (bus.clr_cmd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL rst_next_ack got=%b exp=1", bus.clr_cmd_rdy);
    end
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    checks++;
    if (strt_cal !== 1'b1) begin
      failures++;
      $display("FAIL rst_next_cal got=%b exp=1", strt_cal);
    end
    cal_done = 1'b1;
    @(negedge clk);
    cal_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cal();
    test_move();
    test_fanfare();
    test_saturate();
    test_unknown();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
